// File: rtl/fifo_pkg.sv
// Shared defaults for the systolic-array operand FIFO.
// Pointer width carries one extra wrap bit above the address bits.
package fifo_pkg;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_LENGTH     = 16;
  localparam int DEFAULT_PTR_LENGTH = $clog2(DEFAULT_LENGTH) + 1;

  function automatic int ptr_length(input int length);
    return $clog2(length) + 1;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port.
// No reset on the array; contents survive a FIFO reset.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);
  logic [DATA_WIDTH-1:0] r_mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/fifo_mem.sv
// First-word-fall-through FIFO with full/empty/half-full and sticky
// overflow/underflow status; pointers carry a wrap bit.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LENGTH     = DEFAULT_LENGTH,
  parameter int PTR_LENGTH = ptr_length(LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_threshold,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow,
  output logic                  enable
);
  localparam int ADDR_WIDTH = PTR_LENGTH - 1;
  localparam logic [PTR_LENGTH-1:0] FULL_XOR = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PTR_LENGTH-1:0] HALF     = PTR_LENGTH'(LENGTH / 2);
  localparam logic [PTR_LENGTH-1:0] ONE      = PTR_LENGTH'(1);

  logic [PTR_LENGTH-1:0] r_wptr;
  logic [PTR_LENGTH-1:0] r_rptr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [PTR_LENGTH-1:0] w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_wr_reject;
  logic                  w_rd_reject;
  logic                  w_ram_wr_en;

  assign w_count = r_wptr - r_rptr;
  assign w_full  = ((r_wptr ^ r_rptr) == FULL_XOR);
  assign w_empty = (r_wptr == r_rptr);

  // A write into a full FIFO still lands if the head is popped on the same edge.
  assign w_wr_accept = write & (~w_full | read);
  assign w_rd_accept = read & ~w_empty;
  assign w_wr_reject = write & w_full & ~read;
  assign w_rd_reject = read & w_empty;

  // Reset wins over a coincident write, so stale memory is left untouched.
  assign w_ram_wr_en = w_wr_accept & reset_n;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_ram_wr_en),
    .i_wr_addr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wr_data (data_in),
    .i_rd_addr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rd_data (data_out)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wptr <= r_wptr + ONE;
      end
      if (w_rd_accept) begin
        r_rptr <= r_rptr + ONE;
      end
      if (w_wr_reject) begin
        r_overflow <= 1'b1;
      end else if (w_rd_accept) begin
        r_overflow <= 1'b0;
      end
      // A rejected read beside an accepted write (empty FIFO) still flags underflow.
      if (w_rd_reject) begin
        r_underflow <= 1'b1;
      end else if (w_wr_accept) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign fifo_full      = w_full;
  assign fifo_empty     = w_empty;
  assign fifo_threshold = (w_count >= HALF);
  assign fifo_overflow  = r_overflow;
  assign fifo_underflow = r_underflow;
  assign enable         = ~w_empty;
endmodule

// File: tb/tb_fifo_mem.sv
// Scoreboard bench for fifo_mem: a queue-based reference model predicts
// popped words and status flags; a negedge monitor compares them.
module tb_fifo_mem;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_threshold;
  logic       fifo_overflow;
  logic       fifo_underflow;
  logic       enable;

  int total = 0;
  int bad = 0;

  // reference model state (value before the coming edge)
  int m_q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  // expected popped words
  int sb_q[$];

  fifo_mem dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .write          (write),
    .read           (read),
    .data_in        (data_in),
    .data_out       (data_out),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_threshold (fifo_threshold),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow),
    .enable         (enable)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock of stimulus; model advances after the edge
  task automatic cycle(input bit wr, input bit rd, input logic [7:0] din);
    bit full;
    bit empty;
    bit acc_rd;
    bit acc_wr;
    full   = (m_q.size() == 16);
    empty  = (m_q.size() == 0);
    acc_rd = rd && !empty;
    acc_wr = wr && (!full || rd);
    write   = wr;
    read    = rd;
    data_in = din;
    if (acc_rd) sb_q.push_back(m_q[0]);
    @(posedge clk);
    if (acc_rd) void'(m_q.pop_front());
    if (acc_wr) m_q.push_back(int'(din));
    if (wr && full && !rd) m_ovf = 1'b1;
    else if (acc_rd) m_ovf = 1'b0;
    if (rd && empty) m_unf = 1'b1;
    else if (acc_wr) m_unf = 1'b0;
    #1;
    write = 1'b0;
    read  = 1'b0;
  endtask

  // reset cycle with read and write both asserted to exercise reset priority
  task automatic do_reset();
    reset_n = 1'b0;
    write   = 1'b1;
    read    = 1'b1;
    data_in = 8'hEE;
    @(posedge clk);
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    reset_n = 1'b1;
    write   = 1'b0;
    read    = 1'b0;
  endtask

  // monitor: flags every cycle, popped word whenever a read meets valid data
  always @(negedge clk) begin
    if (reset_n) begin
      check("full",      32'(fifo_full),      32'(m_q.size() == 16));
      check("empty",     32'(fifo_empty),     32'(m_q.size() == 0));
      check("threshold", 32'(fifo_threshold), 32'(m_q.size() >= 8));
      check("overflow",  32'(fifo_overflow),  32'(m_ovf));
      check("underflow", 32'(fifo_underflow), 32'(m_unf));
      check("enable",    32'(enable),         32'(m_q.size() != 0));
      if (read && enable) begin
        if (sb_q.size() == 0) begin
          check("pop_unexpected", 32'(data_out), 32'hFFFF_FFFF);
        end else begin
          check("pop_data", 32'(data_out), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int wr_pct;
    int rd_pct;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 8'h00);

    // fill 1..16; head stays at 1
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      check("head_during_fill", 32'(data_out), 32'd1);
    end
    cycle(1'b1, 1'b0, 8'd17);
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 8'h00);

    // full with simultaneous read/write across pointer wrap
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 24; i++) cycle(1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);

    // reset with 5 words queued, then new data must come back
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
    do_reset();
    cycle(1'b1, 1'b0, 8'hA5);
    check("post_reset_head", 32'(data_out), 32'hA5);
    cycle(1'b0, 1'b1, 8'h00);

    // random traffic with shifting bias and occasional resets
    wr_pct = 50;
    rd_pct = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        wr_pct = $urandom_range(20, 80);
        rd_pct = $urandom_range(20, 80);
      end
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < rd_pct, 8'($urandom));
      end
    end
    for (int i = 0; i < 18; i++) cycle(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
